// File: rtl/z80_serial_bus_master_if.sv
// Signal bundle between the serial bus master and its UART byte ports / Z80 memory bus.
// master: the bus-master block; slave: the surrounding UART + memory environment.
interface z80_serial_bus_master_if;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_busy;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic [7:0]  din;
  logic        mreq_n;
  logic        rd_n;
  logic        wr_n;
  logic        wait_n;
  logic        active;
  logic        overrun;

  modport master (
    input  rx_valid, rx_byte, tx_busy, bus_gnt, din, wait_n,
    output tx_valid, tx_byte, bus_req, addr, dout, mreq_n, rd_n, wr_n, active, overrun
  );

  modport slave (
    output rx_valid, rx_byte, tx_busy, bus_gnt, din, wait_n,
    input  tx_valid, tx_byte, bus_req, addr, dout, mreq_n, rd_n, wr_n, active, overrun
  );
endinterface

// File: rtl/z80_serial_bus_master.sv
// Serial command parser driving single Z80 memory read/write cycles as bus initiator.
// Commands: 'W' AH AL D -> write, reply 0x06; 'R' AH AL -> read, reply data; else reply 0x15.
module z80_serial_bus_master #(
  parameter int unsigned WAIT_TIMEOUT = 1024,
  parameter int unsigned RX_TIMEOUT   = 65535
) (
  input logic                    clk,
  input logic                    rst_n,
  z80_serial_bus_master_if.master bus
);

  localparam int unsigned WTW = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam int unsigned RXW = (RX_TIMEOUT > 0) ? $clog2(RX_TIMEOUT + 1) : 1;
  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  typedef enum logic [2:0] {IDLE, GET_AH, GET_AL, GET_D, BUSREQ, STROBE, RESP} state_t;

  state_t         state, state_d;
  logic           is_wr, is_wr_d;
  logic [7:0]     ah, ah_d, al, al_d, data, data_d;
  logic [RXW-1:0] rx_cnt, rx_cnt_d;
  logic [WTW-1:0] wt_cnt, wt_cnt_d;
  logic           tx_valid_q, tx_valid_d;
  logic [7:0]     tx_byte_q, tx_byte_d;
  logic           bus_req_q, bus_req_d;
  logic [15:0]    addr_q, addr_d;
  logic [7:0]     dout_q, dout_d;
  logic           mreq_n_q, mreq_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic           active_q, active_d, overrun_q, overrun_d;
  logic           rx_expired, wt_expired, finish;

  // Counters saturate at the limit; a zero limit disables the check entirely.
  assign rx_expired = (RX_TIMEOUT != 0) && (rx_cnt == RXW'(RX_TIMEOUT - 1));
  assign wt_expired = (WAIT_TIMEOUT != 0) && (wt_cnt == WTW'(WAIT_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      is_wr      <= 1'b0;
      ah         <= '0;
      al         <= '0;
      data       <= '0;
      rx_cnt     <= '0;
      wt_cnt     <= '0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= '0;
      bus_req_q  <= 1'b0;
      addr_q     <= '0;
      dout_q     <= '0;
      mreq_n_q   <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      active_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state      <= state_d;
      is_wr      <= is_wr_d;
      ah         <= ah_d;
      al         <= al_d;
      data       <= data_d;
      rx_cnt     <= rx_cnt_d;
      wt_cnt     <= wt_cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_byte_q  <= tx_byte_d;
      bus_req_q  <= bus_req_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      mreq_n_q   <= mreq_n_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      active_q   <= active_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state;
    is_wr_d    = is_wr;
    ah_d       = ah;
    al_d       = al;
    data_d     = data;
    rx_cnt_d   = rx_cnt;
    wt_cnt_d   = wt_cnt;
    tx_valid_d = tx_valid_q;
    tx_byte_d  = tx_byte_q;
    bus_req_d  = bus_req_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    mreq_n_d   = mreq_n_q;
    rd_n_d     = rd_n_q;
    wr_n_d     = wr_n_q;
    finish     = 1'b0;
    overrun_d  = bus.rx_valid && (state inside {BUSREQ, STROBE, RESP});

    if (!(wt_cnt == WTW'(WAIT_TIMEOUT)) && WAIT_TIMEOUT != 0)
      wt_cnt_d = wt_cnt + WTW'(1);
    if (!(rx_cnt == RXW'(RX_TIMEOUT)) && RX_TIMEOUT != 0)
      rx_cnt_d = rx_cnt + RXW'(1);

    case (state)
      IDLE: begin
        if (bus.rx_valid) begin
          rx_cnt_d = '0;
          if (bus.rx_byte == OP_W || bus.rx_byte == OP_R) begin
            is_wr_d = (bus.rx_byte == OP_W);
            state_d = GET_AH;
          end else begin
            tx_byte_d = NAK;
            state_d   = RESP;
          end
        end
      end
      GET_AH, GET_AL, GET_D: begin
        if (bus.rx_valid) begin
          rx_cnt_d = '0;
          if (state == GET_AH) begin
            ah_d    = bus.rx_byte;
            state_d = GET_AL;
          end else if (state == GET_AL) begin
            al_d    = bus.rx_byte;
            state_d = is_wr ? GET_D : BUSREQ;
          end else begin
            data_d  = bus.rx_byte;
            state_d = BUSREQ;
          end
          if (state_d == BUSREQ) begin
            bus_req_d = 1'b1;
            wt_cnt_d  = '0;
          end
        end else if (rx_expired) begin
          state_d = IDLE;
        end
      end
      BUSREQ: begin
        // A timeout on the grant edge wins: no strobe is started that late.
        if (wt_expired) begin
          tx_byte_d = NAK;
          finish    = 1'b1;
        end else if (bus.bus_gnt) begin
          addr_d   = {ah, al};
          mreq_n_d = 1'b0;
          if (is_wr) begin
            dout_d = data;
            wr_n_d = 1'b0;
          end else begin
            rd_n_d = 1'b0;
          end
          state_d = STROBE;
        end
      end
      STROBE: begin
        if (bus.wait_n) begin
          tx_byte_d = is_wr ? ACK : bus.din;
          finish    = 1'b1;
        end else if (wt_expired) begin
          tx_byte_d = NAK;
          finish    = 1'b1;
        end
      end
      RESP: begin
        if (!tx_valid_q) begin
          if (!bus.tx_busy) tx_valid_d = 1'b1;
        end else if (bus.tx_busy) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      mreq_n_d  = 1'b1;
      rd_n_d    = 1'b1;
      wr_n_d    = 1'b1;
      bus_req_d = 1'b0;
      state_d   = RESP;
    end
    active_d = (state_d != IDLE);
  end

  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_byte  = tx_byte_q;
  assign bus.bus_req  = bus_req_q;
  assign bus.addr     = addr_q;
  assign bus.dout     = dout_q;
  assign bus.mreq_n   = mreq_n_q;
  assign bus.rd_n     = rd_n_q;
  assign bus.wr_n     = wr_n_q;
  assign bus.active   = active_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_z80_serial_bus_master.sv
// Bench for z80_serial_bus_master: each command's expected waveform is derived as edge-time
// windows from the protocol rules, then checked against the DUT on every cycle.
module tb_z80_serial_bus_master;
  localparam int WT  = 16;
  localparam int RXT = 100;
  localparam int INF = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst_n;
  z80_serial_bus_master_if bif ();

  z80_serial_bus_master #(.WAIT_TIMEOUT(WT), .RX_TIMEOUT(RXT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_fail = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  // Expected-waveform model: edge numbers at which each output window opens/closes.
  int m_act, m_end, m_req, m_s, m_e, m_resp, m_v, m_vf, m_ovr, m_rst;
  bit m_wr;
  logic [15:0] m_a, p_a;
  logic [7:0]  m_d, p_d, m_rsp, p_tx;

  // Observation counters, cumulative; scenarios look at differences.
  int wr_low = 0, rd_low = 0, mq_low = 0, req_hi = 0, txv_hi = 0, act_hi = 0, ovr_hi = 0;
  logic [7:0]  last_tx = '0, last_d = '0;
  logic [15:0] last_a = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [38:0] model(input int k);
    logic strobe, br, tv, ac, ov;
    logic [7:0] tb8, dd;
    logic [15:0] aa;
    if (k >= m_rst) return {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00};
    br     = (k >= m_req) && (k < m_e);
    strobe = (k >= m_s) && (k < m_e);
    tv     = (k >= m_v) && (k < m_vf);
    ac     = (k >= m_act) && (k < m_end);
    ov     = (k == m_ovr);
    tb8    = (k >= m_resp) ? m_rsp : p_tx;
    aa     = (k >= m_s) ? m_a : p_a;
    dd     = (m_wr && k >= m_s) ? m_d : p_d;
    return {br, !strobe, !(strobe && !m_wr), !(strobe && m_wr), tv, ac, ov, tb8, aa, dd};
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check($sformatf("outputs@%0d", cyc),
            {25'b0, bif.bus_req, bif.mreq_n, bif.rd_n, bif.wr_n, bif.tx_valid, bif.active,
             bif.overrun, bif.tx_byte, bif.addr, bif.dout},
            {25'b0, model(cyc)});
      if (!bif.wr_n)   wr_low++;
      if (!bif.rd_n)   rd_low++;
      if (bif.bus_req) req_hi++;
      if (bif.active)  act_hi++;
      if (bif.overrun) ovr_hi++;
      if (!bif.mreq_n) begin
        mq_low++;
        last_a = bif.addr;
        last_d = bif.dout;
      end
      if (bif.tx_valid) begin
        txv_hi++;
        last_tx = bif.tx_byte;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic clear_model();
    m_act = INF; m_end = INF; m_req = INF; m_s = INF; m_e = INF; m_resp = INF;
    m_v = INF; m_vf = INF; m_ovr = INF; m_rst = INF; m_wr = 1'b0;
    m_a = '0; m_d = '0; m_rsp = '0;
  endtask

  task automatic drive_idle();
    bif.rx_valid = 1'b0; bif.rx_byte = '0; bif.bus_gnt = 1'b0;
    bif.wait_n = 1'b1; bif.tx_busy = 1'b0; rst_n = 1'b1;
  endtask

  // g: grant seen g edges after bus_req rises (0 = never); w: wait_n=0 strobe edges;
  // p: tx_busy already high for p edges in RESP; h: edges tx_valid is held before tx_busy.
  task automatic run_cmd(input int nb, input logic [7:0] b0, b1, b2, b3,
                         input int gap, g, w, p, h, ovr_off, rst_off, input logic [7:0] dv);
    int bt[4];
    logic [7:0] bb[4];
    int need, stop, n;
    logic [38:0] v;
    bb[0] = b0; bb[1] = b1; bb[2] = b2; bb[3] = b3;
    need = (b0 == 8'h57) ? 4 : (b0 == 8'h52) ? 3 : 1;
    clear_model();
    for (int i = 0; i < 4; i++) bt[i] = cyc + 2 + i * gap;
    m_act = bt[0];
    if (need == 1) begin
      m_resp = bt[0]; m_e = bt[0]; m_rsp = 8'h15;
      m_v = m_e + p + 1; m_vf = m_v + h; m_end = m_vf;
    end else if (nb < need) begin
      m_end = bt[nb-1] + RXT;
    end else begin
      m_wr = (b0 == 8'h57); m_a = {b1, b2}; m_d = b3;
      m_req = bt[need-1];
      if (g > 0 && g < WT) begin
        m_s = m_req + g;
        if (m_s + w + 1 <= m_req + WT) begin
          m_e = m_s + w + 1; m_rsp = m_wr ? 8'h06 : dv;
        end else begin
          m_e = m_req + WT; m_rsp = 8'h15;
        end
      end else begin
        m_e = m_req + WT; m_rsp = 8'h15;
      end
      m_resp = m_e; m_v = m_e + p + 1; m_vf = m_v + h; m_end = m_vf;
      if (ovr_off > 0) m_ovr = m_s + ovr_off;
      if (rst_off > 0) m_rst = m_s + rst_off;
    end
    stop = (m_rst != INF) ? m_rst + 4 : m_end + 4;
    bif.din = dv;
    while (cyc < stop) begin
      n = cyc + 1;
      bif.rx_valid = 1'b0;
      for (int i = 0; i < nb; i++)
        if (n == bt[i]) begin bif.rx_valid = 1'b1; bif.rx_byte = bb[i]; end
      if (n == m_ovr) begin bif.rx_valid = 1'b1; bif.rx_byte = 8'hEE; end
      bif.bus_gnt = (g > 0) && (m_req != INF) && (n >= m_req + g);
      bif.wait_n  = !(n <= m_s + w);
      bif.tx_busy = (n >= m_e + 1 && n <= m_e + p) || (n >= m_vf && n < m_vf + 3);
      rst_n       = !(n >= m_rst && n < m_rst + 2);
      tick();
    end
    drive_idle();
    v = model(cyc);
    clear_model();
    p_d = v[7:0]; p_a = v[23:8]; p_tx = v[31:24];
  endtask

  int s_wr, s_rd, s_mq, s_req, s_txv, s_act, s_ovr;
  task automatic snap();
    s_wr = wr_low; s_rd = rd_low; s_mq = mq_low; s_req = req_hi;
    s_txv = txv_hi; s_act = act_hi; s_ovr = ovr_hi;
  endtask

  initial begin
    clear_model();
    m_rst = 0; p_a = '0; p_d = '0; p_tx = '0;
    rst_n = 1'b0; bif.rx_valid = 1'b1; bif.rx_byte = 8'h57; bif.bus_gnt = 1'b1;
    bif.wait_n = 1'b1; bif.tx_busy = 1'b0; bif.din = 8'h00;
    tick();
    chk_on = 1'b1;
    tick();
    bif.rx_valid = 1'b0;
    tick();
    drive_idle();
    tick(); tick();
    clear_model();

    // write: grant 3 edges after bus_req, no wait
    snap();
    run_cmd(4, 8'h57, 8'h12, 8'h34, 8'hA5, 1, 3, 0, 0, 3, 0, 0, 8'h00);
    check("wr_low_cycles", 64'(wr_low - s_wr), 64'd1);
    check("wr_rd_low", 64'(rd_low - s_rd), 64'd0);
    check("wr_addr", 64'(last_a), 64'h1234);
    check("wr_dout", 64'(last_d), 64'hA5);
    check("wr_reply", 64'(last_tx), 64'h06);

    // read with 5 wait cycles, tx busy on entry, overrun byte mid-strobe
    snap();
    run_cmd(3, 8'h52, 8'h80, 8'h00, 8'h00, 2, 1, 5, 2, 2, 3, 0, 8'h3C);
    check("rdw_low_cycles", 64'(rd_low - s_rd), 64'd6);
    check("rdw_reply", 64'(last_tx), 64'h3C);
    check("rdw_overrun", 64'(ovr_hi - s_ovr), 64'd1);

    // unknown opcode
    snap();
    run_cmd(1, 8'h41, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 2, 0, 0, 8'h00);
    check("bad_busreq", 64'(req_hi - s_req), 64'd0);
    check("bad_reply", 64'(last_tx), 64'h15);

    // wait_n stuck low
    snap();
    run_cmd(3, 8'h52, 8'h55, 8'hAA, 8'h00, 1, 2, 1000, 0, 2, 0, 0, 8'h77);
    check("to_req_cycles", 64'(req_hi - s_req), 64'd16);
    check("to_rd_cycles", 64'(rd_low - s_rd), 64'd14);
    check("to_reply", 64'(last_tx), 64'h15);

    // grant never given
    snap();
    run_cmd(4, 8'h57, 8'h00, 8'h01, 8'hFF, 1, 0, 0, 0, 2, 0, 0, 8'h00);
    check("ng_req_cycles", 64'(req_hi - s_req), 64'd16);
    check("ng_mreq", 64'(mq_low - s_mq), 64'd0);
    check("ng_reply", 64'(last_tx), 64'h15);

    // partial command abandoned
    snap();
    run_cmd(2, 8'h57, 8'h12, 8'h00, 8'h00, 1, 1, 0, 0, 2, 0, 0, 8'h00);
    check("part_active", 64'(act_hi - s_act), 64'd101);
    check("part_busreq", 64'(req_hi - s_req), 64'd0);
    check("part_tx", 64'(txv_hi - s_txv), 64'd0);

    // normal read after discard
    snap();
    run_cmd(3, 8'h52, 8'h00, 8'h10, 8'h00, 1, 1, 0, 0, 2, 0, 0, 8'h99);
    check("rd_low_cycles", 64'(rd_low - s_rd), 64'd1);
    check("rd_addr", 64'(last_a), 64'h0010);
    check("rd_reply", 64'(last_tx), 64'h99);

    // reset mid-strobe
    snap();
    run_cmd(3, 8'h52, 8'h12, 8'h00, 8'h00, 1, 1, 10, 0, 2, 0, 3, 8'hC3);
    check("rst_tx", 64'(txv_hi - s_txv), 64'd0);

    // completion on the same edge the timeout is reached
    snap();
    run_cmd(3, 8'h52, 8'hAB, 8'hCD, 8'h00, 1, 5, 10, 1, 2, 0, 0, 8'h5A);
    check("edge_rd_cycles", 64'(rd_low - s_rd), 64'd11);
    check("edge_reply", 64'(last_tx), 64'h5A);

    // write after reset, with wait states
    snap();
    run_cmd(4, 8'h57, 8'hFF, 8'hFF, 8'h00, 1, 2, 2, 0, 1, 0, 0, 8'h00);
    check("wr2_low_cycles", 64'(wr_low - s_wr), 64'd3);
    check("wr2_addr", 64'(last_a), 64'hFFFF);
    check("wr2_reply", 64'(last_tx), 64'h06);

    tick();
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
